// File: rtl/decode_issue.sv
// Decode/issue stage: classifies RV32I instructions, builds immediates, reads operands, tracks pending writes.
// Latency: an accepted instruction shows up on the out_* register one cycle later.
// Backpressure: in_ready drops when the output slot is full and not draining, on a source hazard, during flush or reset.
module decode_issue #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [Width-1:0] in_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             rs1_valid,
  output logic             rs2_valid,
  input  logic [Width-1:0] rs1_data,
  input  logic [Width-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_pc,
  output logic [Width-1:0] out_imm,
  output logic [Width-1:0] out_op1,
  output logic [Width-1:0] out_op2,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [4:0]       out_rd,
  output logic             out_rd_valid,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rd;
  logic              w_fmt_r, w_fmt_i, w_fmt_s, w_fmt_b, w_fmt_u, w_fmt_j;
  logic              w_illegal;
  logic              w_use_rs1, w_use_rs2, w_use_rd;
  logic signed [31:0] w_imm32;
  logic [Width-1:0]  w_imm;
  logic [Width-1:0]  w_op1, w_op2;
  logic              w_hazard;
  logic              w_accept;
  logic [31:0]       w_busy_nxt;

  logic [31:0]       r_busy;
  logic              r_out_valid;
  logic [Width-1:0]  r_out_pc, r_out_imm, r_out_op1, r_out_op2;
  logic [6:0]        r_out_opcode;
  logic [2:0]        r_out_funct3;
  logic              r_out_funct7b5;
  logic [4:0]        r_out_rd;
  logic              r_out_rd_valid;
  logic              r_out_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];

  // Classify the opcode into its encoding format; anything unlisted is illegal
  always_comb begin
    w_fmt_r = 1'b0;
    w_fmt_i = 1'b0;
    w_fmt_s = 1'b0;
    w_fmt_b = 1'b0;
    w_fmt_u = 1'b0;
    w_fmt_j = 1'b0;
    case (w_opcode)
      OP_R:                       w_fmt_r = 1'b1;
      OP_IMM, OP_LOAD, OP_JALR:   w_fmt_i = 1'b1;
      OP_STORE:                   w_fmt_s = 1'b1;
      OP_BRANCH:                  w_fmt_b = 1'b1;
      OP_LUI, OP_AUIPC:           w_fmt_u = 1'b1;
      OP_JAL:                     w_fmt_j = 1'b1;
      default:                    ;
    endcase
  end

  assign w_illegal = !(w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b | w_fmt_u | w_fmt_j);
  assign w_use_rs1 = w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b;
  assign w_use_rs2 = w_fmt_r | w_fmt_s | w_fmt_b;
  // Writes to x0 are discarded, so they never claim a scoreboard entry
  assign w_use_rd  = (w_fmt_r | w_fmt_i | w_fmt_u | w_fmt_j) && (w_rd != 5'd0);

  assign rs1_valid = in_valid && w_use_rs1;
  assign rs2_valid = in_valid && w_use_rs2;

  // Assemble the sign-extended immediate for the decoded format (R-type and illegal give zero)
  always_comb begin
    w_imm32 = '0;
    if (w_fmt_i)
      w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    else if (w_fmt_s)
      w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    else if (w_fmt_b)
      w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    else if (w_fmt_u)
      w_imm32 = {in_instr[31:12], 12'h000};
    else if (w_fmt_j)
      w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  end

  assign w_imm = Width'(w_imm32);
  assign w_op1 = w_use_rs1 ? rs1_data : '0;
  assign w_op2 = w_use_rs2 ? rs2_data : '0;

  // No bypass network: a busy source simply stalls; busy[0] is held at zero so x0 never stalls
  assign w_hazard = (w_use_rs1 && r_busy[rs1]) || (w_use_rs2 && r_busy[rs2]);
  assign in_ready = !reset && (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  // Scoreboard update: writeback and flush release first, a new issue claiming rd wins over both
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid)
      w_busy_nxt[wb_rd] = 1'b0;
    if (flush && r_out_valid && r_out_rd_valid)
      w_busy_nxt[r_out_rd] = 1'b0;
    if (w_accept && w_use_rd)
      w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  // Output slot: load on accept, empty on flush or on a downstream transfer with nothing new behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_imm      <= '0;
      r_out_op1      <= '0;
      r_out_op2      <= '0;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_funct7b5 <= 1'b0;
      r_out_rd       <= '0;
      r_out_rd_valid <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else if (flush) begin
      r_out_valid    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= in_pc;
      r_out_imm      <= w_imm;
      r_out_op1      <= w_op1;
      r_out_op2      <= w_op2;
      r_out_opcode   <= w_opcode;
      r_out_funct3   <= in_instr[14:12];
      r_out_funct7b5 <= in_instr[30];
      r_out_rd       <= w_rd;
      r_out_rd_valid <= w_use_rd;
      r_out_illegal  <= w_illegal;
    end else if (out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_imm      = r_out_imm;
  assign out_op1      = r_out_op1;
  assign out_op2      = r_out_op2;
  assign out_opcode   = r_out_opcode;
  assign out_funct3   = r_out_funct3;
  assign out_funct7b5 = r_out_funct7b5;
  assign out_rd       = r_out_rd;
  assign out_rd_valid = r_out_rd_valid;
  assign out_illegal  = r_out_illegal;

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter: Width, 32, datapath width of PC, immediate and operand data.
REQ-002 SHALL have ports: clk  input  1  clock, rising edge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid/in_ready  input/output  1/1  fetch handshake; in_instr  input  32  instruction; in_pc  input  Width  PC.
REQ-005 SHALL have ports: rs1, rs2  output  5 each  register-file read addresses; rs1_valid, rs2_valid  output  1 each  read enables.
REQ-006 SHALL have ports: rs1_data, rs2_data  input  Width each  combinational register-file read data.
REQ-007 SHALL have ports: out_valid/out_ready  output/input  1/1  execute handshake; out_pc, out_imm, out_op1, out_op2  output  Width each.
REQ-008 SHALL have ports: out_opcode  output  7; out_funct3  output  3; out_funct7b5  output  1; out_rd  output  5; out_rd_valid  output  1; out_illegal  output  1.
REQ-009 SHALL have ports: wb_valid  input  1, wb_rd  input  5  writeback completion; flush  input  1  discard output entry.

Function
REQ-010 SHALL drive rs1=in_instr[19:15], rs2=in_instr[24:20] combinationally; rsN_valid=in_valid AND the opcode uses that source.
REQ-011 SHALL classify opcodes: R 0110011; I 0010011/0000011/1100111; S 0100011; B 1100011; U 0110111/0010111; J 1101111; anything else illegal.
REQ-012 SHALL use sources: rs1 for R/I/S/B; rs2 for R/S/B; rd (in_instr[11:7]) for R/I/U/J only when rd!=0.
REQ-013 SHALL generate a sign-extended immediate per RV32I format (I, S, B, U, J); R-type and illegal produce 0.
REQ-014 SHALL keep a scoreboard busy[31:1]; x0 is never busy.
REQ-015 SHALL assert hazard when a used source register (nonzero) is busy; no bypass, so the instruction waits until the bit clears.
REQ-016 SHALL set in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-017 SHALL, on accept (in_valid && in_ready), load the output register at the next edge with PC, immediate, rs1_data/rs2_data (0 when unused), fields and rd info; out_valid=1. Latency: 1 cycle.
REQ-018 SHALL, on accept with rd used, set busy[rd] at the same edge.
REQ-019 SHALL clear busy[wb_rd] on wb_valid (wb_rd!=0); when set and clear target the same register in one cycle, set wins.
REQ-020 SHALL clear out_valid when out_ready && out_valid and no new accept occurs.
REQ-021 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-022 SHALL, on flush, clear out_valid at the next edge and release busy[out_rd] if the dropped entry had out_rd_valid; no accept occurs that cycle.
REQ-023 SHALL flag illegal opcodes with out_illegal=1 and out_rd_valid=0, and still pass them downstream.

Reset
REQ-024 SHALL, on reset, clear out_valid, busy[31:1], out_rd_valid and out_illegal to 0; set out_pc, out_imm, out_op1, out_op2, out_opcode, out_funct3, out_funct7b5 and out_rd to 0.
REQ-025 SHALL have reset dominate flush, wb_valid and any accept in the same cycle; in_ready=0 while reset is high.

Verification
REQ-026 SHALL cover: accept ADDI x5,x1,-1 (0xFFF08293) with x1=7 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_op1=7, out_rd=5, busy[5]=1.
REQ-027 SHALL cover: ADD x6,x5,x5 right after ADDI x5 -> in_ready=0 until wb_valid with wb_rd=5; accepted in the next cycle.
REQ-028 SHALL cover: out_ready=0 for 3 cycles with a valid entry -> outputs stable, in_ready=0; out_ready=1 -> transfer, then next accept.
REQ-029 SHALL cover: flush with pending entry rd=9 -> out_valid=0 next cycle, busy[9]=0.
REQ-030 SHALL cover: in_instr=0xFFFFFFFF -> out_illegal=1, out_rd_valid=0, scoreboard unchanged; LUI x0 -> busy unchanged.
REQ-031 SHALL cover: wb_valid clearing x3 on the same cycle an instruction writing x3 is accepted -> busy[3]=1.
